// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared defaults and interval type for the zero-event interval monitor

package count_mon_pkg;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_IW    = 8;

   typedef logic [DEF_IW-1:0] intv_t;
endpackage

// File: rtl/count_mon_fifo.sv
// rtl/count_mon_fifo.sv - interval FIFO; simultaneous push and pop both succeed, even when full

module count_mon_fifo
   import count_mon_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_IW
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_push_data;
   end
endmodule

// File: rtl/count_zero_monitor.sv
// rtl/count_zero_monitor.sv - measures cycles between upstream zero events and queues them
// COUNT_MON_JUMP_CHECK_EN adds the upstream sequence checker driving err_jump.

module count_zero_monitor
   import count_mon_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int IW    = DEF_IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    number,
   input  logic          zero,
   input  logic          set,
   output logic [IW-1:0] intv_data,
   output logic          intv_valid,
   input  logic          intv_ready,
   output logic          fifo_full,
   output logic [IW-1:0] drop_cnt,
   output logic          err_jump
);
   localparam logic [IW-1:0] SAT = '1;

   logic [IW-1:0] r_gap;
   logic          r_armed;
   logic [IW-1:0] r_drop;
   logic          w_push;
   logic          w_drop;
   logic          w_empty;

   assign w_push     = zero && r_armed;
   assign w_drop     = w_push && fifo_full && !intv_ready;
   assign intv_valid = !w_empty;
   assign drop_cnt   = r_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap   <= '0;
         r_armed <= 1'b0;
         r_drop  <= '0;
      end else begin
         if (zero) begin
            r_gap   <= IW'(1);
            r_armed <= 1'b1;
         end else if (r_gap != SAT) begin
            r_gap <= r_gap + IW'(1);
         end
         if (w_drop && r_drop != SAT) r_drop <= r_drop + IW'(1);
      end
   end

   count_mon_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_push      (w_push),
      .i_push_data (r_gap),
      .i_pop       (intv_ready),
      .o_data      (intv_data),
      .o_full      (fifo_full),
      .o_empty     (w_empty)
   );

`ifdef COUNT_MON_JUMP_CHECK_EN
   logic [3:0] r_prev_num;
   logic       r_prev_set;
   logic       r_have_prev;
   logic       r_err;
   logic [3:0] w_exp_num;
   logic       w_seq_err;
   logic       w_zero_err;

   // A load strobe makes the following sample arbitrary, so only the increment check is skipped.
   assign w_exp_num  = r_prev_num + 4'd1;
   assign w_seq_err  = r_have_prev && !r_prev_set && (number != w_exp_num);
   assign w_zero_err = zero != (number == 4'd0);
   assign err_jump   = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_num  <= '0;
         r_prev_set  <= 1'b0;
         r_have_prev <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_prev_num  <= number;
         r_prev_set  <= set;
         r_have_prev <= 1'b1;
         r_err       <= w_seq_err || w_zero_err;
      end
   end
`else
   logic w_unused;

   assign w_unused = ^{set, number};
   assign err_jump = 1'b0;
`endif
endmodule

// File: tb/tb_count_zero_monitor.sv
// tb/tb_count_zero_monitor.sv - scoreboard bench for count_zero_monitor

module tb_count_zero_monitor;
   import count_mon_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] number = 4'd0;
   logic       zero = 1'b0;
   logic       set = 1'b0;
   logic       intv_ready = 1'b0;
   intv_t      intv_data;
   intv_t      drop_cnt;
   logic       intv_valid;
   logic       fifo_full;
   logic       err_jump;

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_pops = 0;
   intv_t      last_pop = '0;
   intv_t      q[$];
   int         m_occ = 0;
   logic       m_armed = 1'b0;
   intv_t      m_gap = '0;
   logic [3:0] up_num = 4'd0;

   always #5 clk = ~clk;

   count_zero_monitor #(.DEPTH(DEPTH), .IW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .number     (number),
      .zero       (zero),
      .set        (set),
      .intv_data  (intv_data),
      .intv_valid (intv_valid),
      .intv_ready (intv_ready),
      .fifo_full  (fifo_full),
      .drop_cnt   (drop_cnt),
      .err_jump   (err_jump)
   );

   // Scoreboard: every accepted pop must present the oldest expected interval.
   always @(negedge clk) begin
      if (!rst && intv_valid === 1'b1 && intv_ready === 1'b1) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_pop: got %0d expected no entry", intv_data);
         end else begin
            intv_t exp_v;
            exp_v = q.pop_front();
            if (intv_data !== exp_v) begin
               n_fail++;
               $display("FAIL sb_pop_data: got %0d expected %0d", intv_data, exp_v);
            end
         end
         last_pop = intv_data;
         n_pops++;
      end
   end

   task automatic cycle(input logic [3:0] num, input logic z, input logic st, input logic rdy);
      logic pop_m;
      number = num; zero = z; set = st; intv_ready = rdy;
      pop_m = (m_occ > 0) && rdy;
      if (z) begin
         if (m_armed && (m_occ < DEPTH || pop_m)) begin
            q.push_back(m_gap);
            m_occ++;
         end
         m_armed = 1'b1;
         m_gap = 8'd1;
      end else if (m_gap != 8'hFF) begin
         m_gap = m_gap + 8'd1;
      end
      if (pop_m) m_occ--;
      @(posedge clk); #1;
   endtask

   task automatic up_step(input logic rdy, input logic st, input logic [3:0] nv);
      cycle(up_num, up_num == 4'd0, st, rdy);
      up_num = st ? nv : up_num + 4'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1; zero = 1'b0; set = 1'b0; intv_ready = 1'b0; number = 4'd0;
      q.delete(); m_occ = 0; m_armed = 1'b0; m_gap = '0; up_num = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (intv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", intv_valid); end
      n_checks++; if (intv_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", intv_data); end
      n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
      n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_jump); end
   endtask

   task automatic test_free_run();
      int p0;
      do_reset();
      p0 = n_pops;
      for (int i = 0; i < 64; i++) begin
         up_step(1'b1, 1'b0, 4'd0);
         n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL free_err step %0d: got %b expected 0", i, err_jump); end
      end
      n_checks++; if (n_pops - p0 != 3) begin n_fail++; $display("FAIL free_pop_count: got %0d expected 3", n_pops - p0); end
      n_checks++; if (last_pop !== 8'd16) begin n_fail++; $display("FAIL free_gap: got %0d expected 16", last_pop); end
   endtask

   task automatic test_full_drop();
      do_reset();
      for (int i = 0; i <= 80; i++) begin
         up_step(1'b0, 1'b0, 4'd0);
         if (i == 48) begin
            n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL full_after3: got %b expected 0", fifo_full); end
         end
         if (i == 64) begin
            n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_after4: got %b expected 1", fifo_full); end
            n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_after4: got %0d expected 0", drop_cnt); end
         end
      end
      n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_after5: got %0d expected 1", drop_cnt); end
      n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_after5: got %b expected 1", fifo_full); end
      n_checks++; if (intv_data !== 8'd16) begin n_fail++; $display("FAIL full_head_hold: got %0d expected 16", intv_data); end
   endtask

   task automatic test_same_cycle();
      int p0;
      p0 = n_pops;
      for (int i = 1; i < 16; i++) up_step(1'b0, 1'b0, 4'd0);
      up_step(1'b1, 1'b0, 4'd0);
      n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL same_full: got %b expected 1", fifo_full); end
      n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL same_drop: got %0d expected 1", drop_cnt); end
      for (int i = 0; i < 8; i++) up_step(1'b1, 1'b0, 4'd0);
      n_checks++; if (intv_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", intv_valid); end
      n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL drain_full: got %b expected 0", fifo_full); end
      n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drain_drop: got %0d expected 1", drop_cnt); end
      n_checks++; if (n_pops - p0 != 5) begin n_fail++; $display("FAIL drain_pop_count: got %0d expected 5", n_pops - p0); end
   endtask

   task automatic test_set_load();
      int p0;
      do_reset();
      up_num = 4'd5;
      p0 = n_pops;
      for (int i = 0; i < 14; i++) begin
         up_step(1'b1, up_num == 4'd7 && i < 11, 4'd0);
         n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL set_err step %0d: got %b expected 0", i, err_jump); end
      end
      n_checks++; if (n_pops - p0 != 1) begin n_fail++; $display("FAIL set_pop_count: got %0d expected 1", n_pops - p0); end
      n_checks++; if (last_pop !== 8'd8) begin n_fail++; $display("FAIL set_gap: got %0d expected 8", last_pop); end
   endtask

   task automatic test_gap_saturate();
      int p0;
      do_reset();
      up_step(1'b1, 1'b0, 4'd0);
      p0 = n_pops;
      for (int i = 0; i < 300; i++) up_step(1'b1, up_num == 4'd15 || i == 299, (i == 299) ? 4'd0 : 4'd1);
      for (int i = 0; i < 3; i++) up_step(1'b1, 1'b0, 4'd0);
      n_checks++; if (n_pops - p0 != 1) begin n_fail++; $display("FAIL sat_pop_count: got %0d expected 1", n_pops - p0); end
      n_checks++; if (last_pop !== 8'd255) begin n_fail++; $display("FAIL sat_gap: got %0d expected 255", last_pop); end
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL sat_err: got %b expected 0", err_jump); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i <= 48; i++) up_step(1'b0, 1'b0, 4'd0);
      n_checks++; if (intv_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b expected 1", intv_valid); end
      do_reset();
      n_checks++; if (intv_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_after: got %b expected 0", intv_valid); end
      n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_drop_after: got %0d expected 0", drop_cnt); end
      n_checks++; if (intv_data !== 8'd0) begin n_fail++; $display("FAIL mid_data_after: got %0d expected 0", intv_data); end
      for (int i = 0; i <= 18; i++) begin
         up_step(1'b1, 1'b0, 4'd0);
         if (i == 15) begin
            n_checks++; if (intv_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rearm_only: got %b expected 0", intv_valid); end
         end
         if (i == 16) begin
            n_checks++; if (intv_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_push: got %b expected 1", intv_valid); end
         end
      end
   endtask

   task automatic test_jump();
      do_reset();
`ifdef COUNT_MON_JUMP_CHECK_EN
      cycle(4'd4, 1'b0, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL jump_first: got %b expected 0", err_jump); end
      cycle(4'd5, 1'b0, 1'b0, 1'b1);
      cycle(4'd9, 1'b0, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b1) begin n_fail++; $display("FAIL jump_5_9: got %b expected 1", err_jump); end
      cycle(4'd10, 1'b0, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL jump_one_cycle: got %b expected 0", err_jump); end
      cycle(4'd11, 1'b0, 1'b1, 1'b1);
      cycle(4'd3, 1'b1, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b1) begin n_fail++; $display("FAIL jump_zero_flag: got %b expected 1", err_jump); end
      cycle(4'd4, 1'b0, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL jump_recover: got %b expected 0", err_jump); end
`else
      cycle(4'd4, 1'b0, 1'b0, 1'b1);
      cycle(4'd9, 1'b1, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL nojump_err: got %b expected 0", err_jump); end
      cycle(4'd3, 1'b0, 1'b0, 1'b1);
      n_checks++; if (err_jump !== 1'b0) begin n_fail++; $display("FAIL nojump_err2: got %b expected 0", err_jump); end
`endif
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_full_drop();
      test_same_cycle();
      test_set_load();
      test_gap_saturate();
      test_reset_mid();
      test_jump();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
